// File: rtl/program_sequencer_if.sv
// Control/datapath bundle between the program sequencer and its
// surroundings: start/done handshake, ROM fetch, decoder hints, status.
interface program_sequencer_if #(
  parameter int pc_width    = 10,
  parameter int instr_width = 9,
  parameter int cnt_width   = 16
);
  logic                   start;
  logic [pc_width-1:0]    start_addr;
  logic [instr_width-1:0] instr_rdata;
  logic                   halt;
  logic                   mem_access;
  logic                   mem_ready;
  logic                   is_branch;
  logic                   branch_taken;
  logic [pc_width-1:0]    branch_target;
  logic [pc_width-1:0]    pc;
  logic [instr_width-1:0] instr;
  logic                   commit_en;
  logic                   busy;
  logic                   done;
  logic [cnt_width-1:0]   cycle_count;

  modport master (
    output start, start_addr, instr_rdata,
    output halt, mem_access, mem_ready,
    output is_branch, branch_taken, branch_target,
    input  pc, instr, commit_en,
    input  busy, done, cycle_count
  );

  modport slave (
    input  start, start_addr, instr_rdata,
    input  halt, mem_access, mem_ready,
    input  is_branch, branch_taken, branch_target,
    output pc, instr, commit_en,
    output busy, done, cycle_count
  );
endinterface

// File: rtl/program_sequencer.sv
// Multi-cycle fetch/load/exec sequencer: owns PC and instruction
// register, strobes commits, waits on memory, redirects on BEQ.
module program_sequencer #(
  parameter int pc_width    = 10,
  parameter int instr_width = 9,
  parameter int cnt_width   = 16
) (
  input logic                clk,
  input logic                reset,
  program_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EXEC,
    MEM_WAIT,
    HALTED
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [pc_width-1:0]    pc_q;
  logic [pc_width-1:0]    pc_seq;
  logic [instr_width-1:0] ir_q;
  logic [cnt_width-1:0]   cnt_q;
  logic                   accept;
  logic                   commit;
  logic                   run;

  assign run = (state == FETCH) || (state == LOAD) ||
               (state == EXEC)  || (state == MEM_WAIT);

  // Sequential PC wraps naturally at the address width.
  assign pc_seq = (bus.is_branch && bus.branch_taken)
                ? bus.branch_target
                : pc_q + 1'b1;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE, HALTED: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: state_n = LOAD;
      LOAD:  state_n = EXEC;
      EXEC: begin
        if (bus.halt) begin
          state_n = HALTED;
        end else if (bus.mem_access && !bus.mem_ready) begin
          state_n = MEM_WAIT;
        end else begin
          commit  = 1'b1;
          state_n = FETCH;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          commit  = 1'b1;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else if (accept) begin
      pc_q <= bus.start_addr;
    end else if (commit) begin
      pc_q <= pc_seq;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if (state == LOAD) begin
      ir_q <= bus.instr_rdata;
    end
  end

  // Execution cycle counter saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr       = ir_q;
  assign bus.commit_en   = commit;
  assign bus.busy        = run;
  assign bus.done        = (state == HALTED);
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: ROM/decoder/memory models
// around the DUT, commit scoreboard, immediate-assertion checks.
module tb_program_sequencer;

  localparam int PW = 10;
  localparam int IW = 9;
  localparam int CW = 8;

  localparam logic [IW-1:0] ADD  = 9'h001;
  localparam logic [IW-1:0] LW   = 9'h100;
  localparam logic [IW-1:0] HALT = 9'h1FF;

  typedef struct {
    int pc;
    int rel;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   t0;
  int   mem_lat;
  logic sb_on;
  exp_t sbq[$];

  logic [IW-1:0] rom [1024];
  logic [PW-1:0] btab [16];
  int            ph;
  int            lowcnt;

  program_sequencer_if #(
    .pc_width(PW), .instr_width(IW), .cnt_width(CW)
  ) bus ();

  program_sequencer #(
    .pc_width(PW), .instr_width(IW), .cnt_width(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.instr_rdata <= rom[bus.pc];

  assign bus.halt       = (bus.instr == HALT);
  assign bus.mem_access = bus.instr[8] && !bus.halt;
  assign bus.is_branch  = (bus.instr[8:7] == 2'b01);
  assign bus.branch_target = btab[bus.instr[3:0]];
  assign bus.mem_ready  = (lowcnt >= mem_lat);

  // Memory model: two cycles after a start or commit the new
  // instruction is in EXEC; count not-ready cycles from there.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph     <= 0;
      lowcnt <= 0;
    end else if (bus.commit_en || (bus.start && !bus.busy)) begin
      ph     <= 0;
      lowcnt <= 0;
    end else if (ph < 2) begin
      ph <= ph + 1;
    end else if (bus.mem_access && !bus.mem_ready) begin
      lowcnt <= lowcnt + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_on && bus.commit_en) begin
      total++;
      assert (sbq.size() != 0) else begin
        bad++;
        $error("FAIL commit_extra got=pc%0h exp=none",
               bus.pc);
      end
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("commit_pc", 32'(bus.pc), e.pc);
        check("commit_cycle", cyc - t0 + 1, e.rel);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int addr);
    bus.start_addr = PW'(addr);
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    t0 = cyc;
    check("start_busy", 32'(bus.busy), 1);
    check("start_done", 32'(bus.done), 0);
    check("start_cnt", 32'(bus.cycle_count), 0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && !bus.done; i++) tick();
    check(tag, 32'(bus.done), 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    t0    = 0;
    sb_on = 1'b1;
    mem_lat = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.branch_taken = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = ADD;
    for (int i = 0; i < 16; i++) btab[i] = '0;
    rom[0]    = HALT;
    rom[2]    = LW;
    rom[3]    = HALT;
    rom[5]    = ADD;
    rom[6]    = ADD;
    rom[7]    = HALT;
    rom[10]   = 9'h081;
    rom[11]   = HALT;
    rom[20]   = 9'h082;
    rom[1023] = ADD;
    btab[1]   = 10'd3;
    btab[2]   = 10'd20;

    tick();
    tick();
    check("rst_pc", 32'(bus.pc), 0);
    check("rst_instr", 32'(bus.instr), 0);
    check("rst_cnt", 32'(bus.cycle_count), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 0);

    // ADD, ADD, HALT from 5
    sbq.push_back('{pc: 5, rel: 3});
    sbq.push_back('{pc: 6, rel: 6});
    go(5);
    wait_done("t2_done");
    check("t2_pc", 32'(bus.pc), 7);
    check("t2_cnt", 32'(bus.cycle_count), 9);
    check("t2_instr", 32'(bus.instr), 32'(HALT));
    check("t2_busy", 32'(bus.busy), 0);

    // LW at 2, four not-ready cycles, then HALT at 3
    mem_lat = 4;
    sbq.push_back('{pc: 2, rel: 7});
    go(2);
    wait_done("t3_done");
    check("t3_pc", 32'(bus.pc), 3);
    check("t3_cnt", 32'(bus.cycle_count), 10);
    mem_lat = 0;

    // BEQ at 10 taken -> 3
    bus.branch_taken = 1'b1;
    sbq.push_back('{pc: 10, rel: 3});
    go(10);
    wait_done("t4a_done");
    check("t4a_pc", 32'(bus.pc), 3);
    check("t4a_cnt", 32'(bus.cycle_count), 6);

    // BEQ at 10 not taken -> 11
    bus.branch_taken = 1'b0;
    sbq.push_back('{pc: 10, rel: 3});
    go(10);
    wait_done("t4b_done");
    check("t4b_pc", 32'(bus.pc), 11);
    check("t4b_cnt", 32'(bus.cycle_count), 6);

    // Wrap 1023 -> 0, start pulsed while busy
    sbq.push_back('{pc: 1023, rel: 3});
    go(1023);
    bus.start_addr = 10'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("t5_done");
    check("t5_pc", 32'(bus.pc), 0);
    check("t5_cnt", 32'(bus.cycle_count), 6);

    // Restart at 0 from HALTED
    go(0);
    wait_done("t6_done");
    check("t6_pc", 32'(bus.pc), 0);
    check("t6_cnt", 32'(bus.cycle_count), 3);

    // Self-loop BEQ to saturate the counter
    sb_on = 1'b0;
    bus.branch_taken = 1'b1;
    go(20);
    repeat (270) tick();
    check("sat_cnt", 32'(bus.cycle_count), 255);
    repeat (7) tick();
    check("sat_hold", 32'(bus.cycle_count), 255);
    check("sat_busy", 32'(bus.busy), 1);

    // Reset while a commit is pending
    for (int i = 0; i < 10 && !bus.commit_en; i++) tick();
    check("pre_rst_commit", 32'(bus.commit_en), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_commit", 32'(bus.commit_en), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_pc", 32'(bus.pc), 0);
    check("mid_rst_cnt", 32'(bus.cycle_count), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_pc", 32'(bus.pc), 0);

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Multi-cycle control sequencer for the 9-bit-instruction core. It owns the program counter, fetches from the synchronous instruction ROM into an instruction register and presents that register to the decoder. It gates architectural writes with a one-cycle commit strobe, stalls on data-memory handshakes, applies BEQ redirects and stops on HALT. It sits between the testbench/top-level start/done handshake and the decoder/ALU/register-file datapath.

## Interface
- `pc_width`, default 10: program counter / instruction ROM address width.
- `instr_width`, default 9: instruction width.
- `cnt_width`, default 16: cycle counter width.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin execution at `start_addr`; sampled only in IDLE/HALTED.
- `start_addr`  in  pc_width  first instruction address.
- `instr_rdata`  in  instr_width  ROM read data, valid the cycle after `pc` is presented.
- `halt`  in  1  decoder HALT indication for current `instr`.
- `mem_access`  in  1  decoder mem_read | mem_write for current `instr`.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `is_branch`  in  1  current `instr` is BEQ.
- `branch_taken`  in  1  ALU equality result for BEQ.
- `branch_target`  in  pc_width  absolute target from branch lookup table.
- `pc`  out  pc_width  current PC; drives ROM address.
- `instr`  out  instr_width  instruction register; feeds decoder.
- `commit_en`  out  1  one-cycle enable ANDed with reg_write/car_write/mem_write.
- `busy`  out  1  high in FETCH, LOAD, EXEC, MEM_WAIT.
- `done`  out  1  high in HALTED.
- `cycle_count`  out  cnt_width  cycles spent executing since last accepted start.

## Operation
- States: IDLE, FETCH, LOAD, EXEC, MEM_WAIT, HALTED.
- IDLE: `start`=1 -> pc<=start_addr, cycle_count<=0, go FETCH.
- FETCH: `pc` presented to ROM; go LOAD.
- LOAD: `instr`<=`instr_rdata` at end of cycle; go EXEC.
- EXEC, priority order:
  - `halt`=1 -> HALTED; commit_en=0; pc unchanged (points at HALT).
  - `mem_access`=1 and `mem_ready`=0 -> MEM_WAIT; commit_en=0.
  - otherwise commit_en=1; pc update; go FETCH.
- MEM_WAIT: hold `instr`, `pc`; when `mem_ready`=1, commit_en=1, pc update, go FETCH; else stay.
- PC update: `is_branch` & `branch_taken` -> `branch_target`; else pc+1, modulo 2^pc_width (all-ones wraps to 0).
- `is_branch`/`branch_taken` sampled in the commit cycle only.
- HALTED: done=1 held. `start`=1 -> same as IDLE start (restart); done drops next cycle.
- `start` ignored while busy.
- `cycle_count`: +1 every cycle in FETCH/LOAD/EXEC/MEM_WAIT; saturates at all-ones; frozen in IDLE/HALTED; cleared only on accepted start or reset.
- `commit_en` is combinational from state + inputs; never high outside EXEC/MEM_WAIT; at most one cycle per instruction.

## Timing
- Reset (async, any state): state=IDLE, pc=0, instr=0, cycle_count=0; outputs commit_en=0, busy=0, done=0 immediately while reset high.
- Start accepted at edge N: pc=start_addr, busy=1 after N.
- Non-memory instruction: 3 cycles (FETCH, LOAD, EXEC); commit in EXEC.
- Memory instruction: 3 + k cycles, k = cycles mem_ready held low after EXEC entry; mem_ready=1 in EXEC -> no wait.
- HALT: done=1 on the cycle after EXEC sees halt; cycle_count includes the HALT instruction's 3 cycles.
- `instr` changes only at LOAD->EXEC edge.
- Simultaneous `halt` and `mem_access`: halt wins, no commit.
- Simultaneous `start` and `reset`: reset wins.

## Test plan
- Reset mid-EXEC with commit pending -> commit_en=0 same cycle, state IDLE, pc=0, cycle_count=0, busy=0.
- start_addr=5, ROM[5..7]=ADD,ADD,HALT -> commit_en pulses at cycles 3 and 6 after start, done=1 at cycle 9, pc=7, cycle_count=9.
- LW at pc=2, mem_ready low 4 cycles -> stays MEM_WAIT 4 cycles, single commit_en pulse, pc=3, cycle_count=7 for that instruction.
- BEQ at pc=10, branch_taken=1, branch_target=3 -> next FETCH pc=3; with branch_taken=0 -> pc=11.
- pc_width=10, start_addr=1023, non-branch -> pc wraps to 0; start pulsed while busy -> ignored.
- From HALTED, start with start_addr=0 -> done=0 next cycle, cycle_count cleared, execution restarts at 0; cycle_count forced near all-ones saturates without wrapping.
